// File: rtl/cpu_ram_ws.sv
// Avalon-style RAM slave with base-address window, error flagging and transfer counter.
// Latency: RAM_WAIT (or LFSR-random) wait cycles, then combinational read data in the accept cycle.
// Backpressure: waitrequest held high until the wait count expires; requests must be held until accepted.
module cpu_ram_ws #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter              RAM_FILE    = "",
    parameter int          WAIT_MODE   = 0,
    parameter int          RAM_WAIT    = 0,
    parameter int          WAIT_BITS   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               address,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic [DATA_WIDTH-1:0]     writedata,
    output logic                      waitrequest,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      bus_error,
    output logic [31:0]               xfer_count
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state, state_nxt;
    logic [31:0]            count, count_nxt;
    logic [15:0]            lfsr;
    logic [31:0]            load;
    logic                   req, accept, drop;
    logic [31:0]            off, word;
    logic                   in_range, aligned, addr_ok, both, err_xfer, mem_we;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

    assign req  = read | write;
    assign load = (WAIT_MODE == 1) ? 32'(lfsr[WAIT_BITS-1:0]) : 32'(RAM_WAIT);

    // Address decode; errors still run the full wait sequence before completing.
    assign off      = address - BASE_ADDR;
    assign word     = off >> LB;
    assign in_range = (address >= BASE_ADDR) && (word < 32'(DEPTH_WORDS));
    assign aligned  = (address & 32'(NB - 1)) == 32'd0;
    assign addr_ok  = in_range && aligned;
    assign both     = read && write;
    assign idx      = word[IDX_W-1:0];

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        waitrequest = 1'b1;
        accept      = 1'b0;
        drop        = 1'b0;
        if (reset_n) begin
            case (state)
                S_IDLE: begin
                    waitrequest = req && (load != 32'd0);
                    if (req && (load != 32'd0)) begin
                        state_nxt = S_WAIT;
                        count_nxt = load - 32'd1;
                    end else begin
                        accept = req;
                    end
                end
                S_WAIT: begin
                    waitrequest = (count != 32'd0);
                    if (!req) begin
                        state_nxt = S_IDLE;
                        count_nxt = 32'd0;
                        drop      = 1'b1;
                    end else if (count == 32'd0) begin
                        state_nxt = S_IDLE;
                        accept    = 1'b1;
                    end else begin
                        count_nxt = count - 32'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign err_xfer = accept && (both || !addr_ok);
    assign mem_we   = accept && write && !read && addr_ok;
    assign readdata = (accept && read && !write && addr_ok) ? mem[idx] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            count      <= 32'd0;
            lfsr       <= LFSR_SEED;
            bus_error  <= 1'b0;
            xfer_count <= 32'd0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            bus_error  <= bus_error | err_xfer | drop;
            if (accept)
                xfer_count <= xfer_count + 32'd1;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b])
                    mem[idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_cpu_ram_ws.sv
// Bench for cpu_ram_ws: three instances (0 waits, 3 fixed waits, LFSR waits) on a shared reset.
module tb_cpu_ram_ws;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address [3];
    logic        rd [3];
    logic        wr [3];
    logic [3:0]  be [3];
    logic [31:0] wdat [3];
    logic        wreq [3];
    logic [31:0] rdat [3];
    logic        berr [3];
    logic [31:0] xcnt [3];

    int          ncmp = 0;
    int          nfail = 0;
    int          exp_cnt [3];
    logic [31:0] exp_q [$];
    logic [31:0] model [16];
    bit          seen [8];
    int          w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cpu_ram_ws #(
            .DATA_WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .RAM_FILE(""),
            .WAIT_MODE(g == 2 ? 1 : 0), .RAM_WAIT(g == 1 ? 3 : 0),
            .WAIT_BITS(3), .LFSR_SEED(16'hACE1)
        ) dut (
            .clk(clk), .reset_n(reset_n), .address(address[g]), .read(rd[g]), .write(wr[g]),
            .byteenable(be[g]), .writedata(wdat[g]), .waitrequest(wreq[g]), .readdata(rdat[g]),
            .bus_error(berr[g]), .xfer_count(xcnt[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer on instance u; returns the number of waitrequest-high cycles seen.
    task automatic xfer(input int u, input bit r, input bit wq, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, output int waits);
        logic [31:0] e;
        @(negedge clk);
        address[u] = a; rd[u] = r; wr[u] = wq; be[u] = b; wdat[u] = d;
        waits = 0;
        #1;
        while (wreq[u] === 1'b1 && waits < 40) begin
            chk("no_accept_in_wait", xcnt[u], 32'(exp_cnt[u]));
            if (r) chk("rdata_zero_in_wait", rdat[u], 32'd0);
            waits++;
            @(negedge clk);
            #1;
        end
        chk("wait_bound", 32'(waits < 40), 32'd1);
        if (r && !wq) begin
            e = exp_q.pop_front();
            chk("rdata", rdat[u], e);
        end
        @(posedge clk);
        #1;
        rd[u] = 1'b0; wr[u] = 1'b0;
        exp_cnt[u]++;
        chk("xfer_count", xcnt[u], 32'(exp_cnt[u]));
    endtask

    task automatic rd_chk(input int u, input logic [31:0] a, input logic [31:0] e, output int waits);
        exp_q.push_back(e);
        xfer(u, 1'b1, 1'b0, a, 4'h0, 32'd0, waits);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            address[i] = BASE; rd[i] = 1'b0; wr[i] = 1'b0; be[i] = 4'h0; wdat[i] = 32'd0;
            exp_cnt[i] = 0;
        end
        // Reset: a held request must not be accepted.
        rd[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", 32'(wreq[0]), 32'd1);
        chk("rst_readdata", rdat[0], 32'd0);
        chk("rst_bus_error", 32'(berr[0]), 32'd0);
        chk("rst_xfer_count", xcnt[0], 32'd0);
        rd[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait write then read.
        xfer(0, 1'b0, 1'b1, BASE, 4'hF, 32'hDEADBEEF, w);
        chk("t1_wr_waits", 32'(w), 32'd0);
        rd_chk(0, BASE, 32'hDEADBEEF, w);
        chk("t1_rd_waits", 32'(w), 32'd0);

        // Three fixed waits.
        xfer(1, 1'b0, 1'b1, BASE + 4, 4'hF, 32'hCAFEF00D, w);
        chk("t2_wr_waits", 32'(w), 32'd3);
        rd_chk(1, BASE + 4, 32'hCAFEF00D, w);
        chk("t2_rd_waits", 32'(w), 32'd3);

        // Byte lanes and the empty byteenable.
        xfer(0, 1'b0, 1'b1, BASE + 8, 4'hF, 32'hFFFFFFFF, w);
        xfer(0, 1'b0, 1'b1, BASE + 8, 4'b0101, 32'h11223344, w);
        rd_chk(0, BASE + 8, 32'hFF22FF44, w);
        xfer(0, 1'b0, 1'b1, BASE + 8, 4'h0, 32'h00000000, w);
        rd_chk(0, BASE + 8, 32'hFF22FF44, w);

        // Error transfers: below window, misaligned, above window.
        chk("t4_berr_before", 32'(berr[0]), 32'd0);
        rd_chk(0, BASE - 4, 32'd0, w);
        chk("t4_berr_low", 32'(berr[0]), 32'd1);
        rd_chk(1, BASE + 2, 32'd0, w);
        chk("t4_berr_misalign", 32'(berr[1]), 32'd1);
        chk("t4_misalign_waits", 32'(w), 32'd3);
        xfer(2, 1'b0, 1'b1, BASE + 32'd4096, 4'hF, 32'h0BADF00D, w);
        chk("t4_berr_high", 32'(berr[2]), 32'd1);

        // Reset in the middle of a waited write.
        @(negedge clk);
        address[1] = BASE + 4; wr[1] = 1'b1; be[1] = 4'hF; wdat[1] = 32'h12345678;
        #1;
        chk("t6_wait_before_rst", 32'(wreq[1]), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_wreq_in_rst", 32'(wreq[1]), 32'd1);
        @(negedge clk);
        wr[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        #1;
        chk("t6_berr_after", 32'(berr[1]), 32'd0);
        chk("t6_cnt_after", xcnt[1], 32'd0);
        rd_chk(1, BASE + 4, 32'hCAFEF00D, w);
        chk("t6_idle_waits", 32'(w), 32'd3);

        // Simultaneous read and write is a flagged no-op.
        xfer(0, 1'b1, 1'b1, BASE, 4'hF, 32'h00000000, w);
        chk("t4_berr_rw", 32'(berr[0]), 32'd1);
        rd_chk(0, BASE, 32'hDEADBEEF, w);

        // Random waits against a scoreboard.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xfer(2, 1'b0, 1'b1, BASE + 32'(i * 4), 4'hF, model[i], w);
        end
        for (int n = 0; n < 200; n++) begin
            int          a;
            logic [3:0]  bb;
            logic [31:0] dd;
            a  = $urandom_range(0, 15);
            bb = 4'($urandom_range(0, 15));
            dd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rd_chk(2, BASE + 32'(a * 4), model[a], w);
            end else begin
                xfer(2, 1'b0, 1'b1, BASE + 32'(a * 4), bb, dd, w);
                for (int b = 0; b < 4; b++)
                    if (bb[b]) model[a][8*b +: 8] = dd[8*b +: 8];
            end
            chk("t5_wait_range", 32'(w <= 7), 32'd1);
            if (w <= 7) seen[w] = 1'b1;
        end
        for (int k = 0; k < 8; k++) chk($sformatf("t5_wait_seen_%0d", k), 32'(seen[k]), 32'd1);
        chk("t5_berr", 32'(berr[2]), 32'd0);

        // Request dropped mid-wait: flagged, not counted.
        @(negedge clk);
        address[1] = BASE + 4; rd[1] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("drop_berr", 32'(berr[1]), 32'd1);
        chk("drop_cnt", xcnt[1], 32'(exp_cnt[1]));
        rd_chk(1, BASE + 4, 32'hCAFEF00D, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
